// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the memory-stage load/store unit.
//   mem_oper_t  : memory operation encoding (MEM_NOP = no operation)
//   exc_t       : exception cause codes
//   lsu_state_e : load/store sequencer FSM states
//   helpers     : access size, load/store classification, alignment check
package riscv_pkg;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_oper_t;

    typedef enum logic [4:0] {
        INSTR_ADDR_MISALIGNED     = 5'd0,
        ILLEGAL_INSTR             = 5'd2,
        BREAKPOINT                = 5'd3,
        LOAD_ADDR_MISALIGNED      = 5'd4,
        STORE_AMO_ADDR_MISALIGNED = 5'd6
    } exc_t;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT
    } lsu_state_e;

    // 2'b00 byte, 2'b01 half, 2'b10 word
    function automatic logic [1:0] mem_oper_size(input mem_oper_t oper);
        case (oper)
            MEM_LB, MEM_LBU, MEM_SB: mem_oper_size = 2'b00;
            MEM_LH, MEM_LHU, MEM_SH: mem_oper_size = 2'b01;
            default:                 mem_oper_size = 2'b10;
        endcase
    endfunction

    function automatic logic mem_is_store(input mem_oper_t oper);
        mem_is_store = (oper == MEM_SB) || (oper == MEM_SH) || (oper == MEM_SW);
    endfunction

    function automatic logic mem_is_load(input mem_oper_t oper);
        mem_is_load = (oper != MEM_NOP) && !mem_is_store(oper);
    endfunction

    function automatic logic mem_aligned(input mem_oper_t oper, input logic [1:0] off);
        case (mem_oper_size(oper))
            2'b00:   mem_aligned = 1'b1;
            2'b01:   mem_aligned = !off[0];
            default: mem_aligned = (off == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   Request side : req_oper_i/req_off_i/wdata_i -> be_o (byte enables),
//                  wdata_o (store data replicated to every lane).
//   Response side: rsp_oper_i/rsp_off_i/rdata_i -> rdata_o (selected byte/half
//                  shifted down and sign- or zero-extended).
module lsu_align
    import riscv_pkg::*;
(
    input  logic [3:0]  req_oper_i,
    input  logic [1:0]  req_off_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [3:0]  rsp_oper_i,
    input  logic [1:0]  rsp_off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] rdata_o
);

    mem_oper_t   req_oper;
    mem_oper_t   rsp_oper;
    logic [31:0] rsh;

    assign req_oper = mem_oper_t'(req_oper_i);
    assign rsp_oper = mem_oper_t'(rsp_oper_i);

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (mem_oper_size(req_oper))
            2'b00: begin
                be_o    = 4'b0001 << req_off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o    = 4'b0011 << req_off_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
    end

    always_comb begin
        rsh     = rdata_i >> {rsp_off_i, 3'b000};
        rdata_o = rdata_i;
        case (rsp_oper)
            MEM_LB:  rdata_o = {{24{rsh[7]}}, rsh[7:0]};
            MEM_LBU: rdata_o = {24'h0, rsh[7:0]};
            MEM_LH:  rdata_o = {{16{rsh[15]}}, rsh[15:0]};
            MEM_LHU: rdata_o = {16'h0, rsh[15:0]};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the memory stage and a single-port
// req/gnt/rvalid data bus. One outstanding transaction at most.
//   Pipeline side: req_valid_i, mem_oper_i, addr_i, wdata_i, flush_i in;
//                  busy_o (stall), rdata_o/rvalid_o (load result pulse),
//                  misalign_o/exc_code_o (exception pulse) out.
//   Bus side     : bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o out;
//                  bus_gnt_i, bus_rvalid_i, bus_rdata_i in.
module lsu_ctrl
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic [3:0]        mem_oper_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic [31:0]       rdata_o,
    output logic              rvalid_o,
    output logic              misalign_o,
    output logic [4:0]        exc_code_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_be_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [31:0]       bus_rdata_i
);

    if (DATA_W != 32) begin : g_data_w_check
        $error("lsu_ctrl: DATA_W must be 32");
    end

    lsu_state_e        state_q, state_d;
    mem_oper_t         oper_q, oper_d;
    logic [1:0]        off_q, off_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              misalign_q, misalign_d;
    exc_t              exc_q, exc_d;

    mem_oper_t   oper_in;
    logic        accept;
    logic        aligned;
    logic [3:0]  be_req;
    logic [31:0] wdata_req;
    logic [31:0] rdata_ext;

    assign oper_in = mem_oper_t'(mem_oper_i);
    assign accept  = req_valid_i && (oper_in != MEM_NOP) && (state_q == LSU_IDLE) && !flush_i;
    assign aligned = mem_aligned(oper_in, addr_i[1:0]);

    lsu_align u_align (
        .req_oper_i (mem_oper_i),
        .req_off_i  (addr_i[1:0]),
        .wdata_i    (wdata_i),
        .be_o       (be_req),
        .wdata_o    (wdata_req),
        .rsp_oper_i (oper_q),
        .rsp_off_i  (off_q),
        .rdata_i    (bus_rdata_i),
        .rdata_o    (rdata_ext)
    );

    always_comb begin
        state_d    = state_q;
        oper_d     = oper_q;
        off_d      = off_q;
        drop_d     = drop_q;
        addr_d     = addr_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rvalid_d   = 1'b0;
        rdata_d    = rdata_q;
        misalign_d = 1'b0;
        exc_d      = INSTR_ADDR_MISALIGNED;

        case (state_q)
            LSU_IDLE: begin
                if (accept) begin
                    if (aligned) begin
                        oper_d  = oper_in;
                        off_d   = addr_i[1:0];
                        drop_d  = 1'b0;
                        addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
                        we_d    = mem_is_store(oper_in);
                        be_d    = be_req;
                        wdata_d = wdata_req;
                        state_d = LSU_REQ;
                    end else begin
                        misalign_d = 1'b1;
                        exc_d      = mem_is_store(oper_in) ? STORE_AMO_ADDR_MISALIGNED
                                                           : LOAD_ADDR_MISALIGNED;
                    end
                end
            end
            LSU_REQ: begin
                // A grant coinciding with flush is already committed on the
                // bus, so the response must still be absorbed.
                if (bus_gnt_i) begin
                    state_d = LSU_WAIT;
                    drop_d  = flush_i;
                end else if (flush_i) begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_WAIT: begin
                if (bus_rvalid_i) begin
                    state_d = LSU_IDLE;
                    drop_d  = 1'b0;
                    if (mem_is_load(oper_q) && !drop_q && !flush_i) begin
                        rvalid_d = 1'b1;
                        rdata_d  = rdata_ext;
                    end
                end else if (flush_i) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= LSU_IDLE;
            oper_q     <= MEM_NOP;
            off_q      <= '0;
            drop_q     <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            exc_q      <= INSTR_ADDR_MISALIGNED;
        end else begin
            state_q    <= state_d;
            oper_q     <= oper_d;
            off_q      <= off_d;
            drop_q     <= drop_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            exc_q      <= exc_d;
        end
    end

    assign busy_o      = (state_q != LSU_IDLE) || (accept && aligned);
    assign bus_req_o   = (state_q == LSU_REQ);
    assign bus_we_o    = we_q;
    assign bus_be_o    = be_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign misalign_o  = misalign_q;
    assign exc_code_o  = exc_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl. Directed scenarios plus
// randomized transactions checked against a byte-lane reference model.
module tb_lsu_ctrl;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [3:0]  mem_oper;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        flush;
    logic        busy;
    logic [31:0] rdata;
    logic        rvalid;
    logic        misalign;
    logic [4:0]  exc_code;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int tests = 0;
    int fails = 0;

    // observations recorded by run_txn
    logic        obs_busy0, obs_busy_ok, obs_req_ok, obs_stable_ok, obs_req_after;
    logic        obs_rvalid, obs_busy_end;
    logic [31:0] obs_rdata, obs_addr, obs_wdata;
    logic [3:0]  obs_be;
    logic        obs_we;
    int          obs_rv_cnt;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .mem_oper_i   (mem_oper),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .flush_i      (flush),
        .busy_o       (busy),
        .rdata_o      (rdata),
        .rvalid_o     (rvalid),
        .misalign_o   (misalign),
        .exc_code_o   (exc_code),
        .bus_req_o    (bus_req),
        .bus_we_o     (bus_we),
        .bus_be_o     (bus_be),
        .bus_addr_o   (bus_addr),
        .bus_wdata_o  (bus_wdata),
        .bus_gnt_i    (bus_gnt),
        .bus_rvalid_i (bus_rvalid),
        .bus_rdata_i  (bus_rdata)
    );

    // ---------------- reference model ----------------
    function automatic int m_bytes(input logic [3:0] op);
        if (op == MEM_LB || op == MEM_LBU || op == MEM_SB) return 1;
        if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) return 2;
        return 4;
    endfunction

    function automatic logic m_store(input logic [3:0] op);
        return (op == MEM_SB || op == MEM_SH || op == MEM_SW);
    endfunction

    function automatic logic m_misaligned(input logic [3:0] op, input logic [31:0] a);
        return (a % m_bytes(op)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
        int n = m_bytes(op);
        int mask = (1 << n) - 1;
        int sh = a % 4;
        return 4'((mask << sh) & 15);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
        case (m_bytes(op))
            1:       return (d & 32'hFF) * 32'h0101_0101;
            2:       return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] d);
        logic [31:0] sh = d >> (8 * (a % 4));
        int v;
        case (op)
            MEM_LB:  begin v = int'(sh & 255);   if (v > 127)   v = v - 256;   return 32'(v); end
            MEM_LBU: return sh & 255;
            MEM_LH:  begin v = int'(sh & 65535); if (v > 32767) v = v - 65536; return 32'(v); end
            MEM_LHU: return sh & 65535;
            default: return d;
        endcase
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one aligned transaction with given grant/response delays and
    // records what the DUT did; starts and ends just after a rising edge.
    task automatic run_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int gd, input int rdl);
        obs_busy_ok = 1'b1; obs_req_ok = 1'b1; obs_stable_ok = 1'b1; obs_rv_cnt = 0;
        req_valid = 1'b1; mem_oper = op; addr = a; wdata = wd;
        #1 obs_busy0 = busy;
        tick();
        req_valid = 1'b0; mem_oper = MEM_NOP; addr = $urandom; wdata = $urandom;
        obs_be = bus_be; obs_we = bus_we; obs_addr = bus_addr; obs_wdata = bus_wdata;
        for (int i = 0; i <= gd; i++) begin
            if (!bus_req) obs_req_ok = 1'b0;
            if (!busy) obs_busy_ok = 1'b0;
            if (bus_be !== obs_be || bus_we !== obs_we || bus_addr !== obs_addr ||
                bus_wdata !== obs_wdata) obs_stable_ok = 1'b0;
            if (rvalid) obs_rv_cnt++;
            bus_gnt = (i == gd);
            tick();
            bus_gnt = 1'b0;
        end
        obs_req_after = bus_req;
        for (int i = 0; i <= rdl; i++) begin
            if (!busy) obs_busy_ok = 1'b0;
            if (bus_req) obs_req_ok = 1'b0;
            if (rvalid) obs_rv_cnt++;
            bus_rvalid = (i == rdl);
            bus_rdata  = (i == rdl) ? rd : $urandom;
            tick();
            bus_rvalid = 1'b0;
        end
        obs_rvalid = rvalid; obs_rdata = rdata; obs_busy_end = busy;
        tick();
        if (rvalid) obs_rv_cnt++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; mem_oper = MEM_NOP; addr = '0; wdata = '0;
        flush = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        #1;
        tests++;
        if ({busy, rdata, rvalid, misalign, exc_code, bus_req, bus_we, bus_be, bus_addr, bus_wdata} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b rvalid=%b req=%b be=%h addr=%h wdata=%h rdata=%h, required all 0",
                     busy, rvalid, bus_req, bus_be, bus_addr, bus_wdata, rdata);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lw_basic();
        run_txn(MEM_LW, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 0);
        tests++;
        if (obs_be !== 4'b1111 || obs_addr !== 32'h1000 || obs_we !== 1'b0) begin
            fails++; $display("FAIL lw_bus: be=%b addr=%h we=%b, required 1111 00001000 0", obs_be, obs_addr, obs_we);
        end
        tests++;
        if (obs_rvalid !== 1'b1 || obs_rdata !== 32'hDEADBEEF || obs_rv_cnt != 0) begin
            fails++; $display("FAIL lw_result: rvalid=%b rdata=%h extra=%0d, required 1 deadbeef 0", obs_rvalid, obs_rdata, obs_rv_cnt);
        end
        tests++;
        if (obs_busy0 !== 1'b1 || obs_busy_ok !== 1'b1 || obs_busy_end !== 1'b0) begin
            fails++; $display("FAIL lw_busy: c0=%b c1_2=%b c3=%b, required 1 1 0", obs_busy0, obs_busy_ok, obs_busy_end);
        end
        tests++;
        if (obs_req_ok !== 1'b1 || obs_req_after !== 1'b0) begin
            fails++; $display("FAIL lw_req: during=%b after_gnt=%b, required 1 0", obs_req_ok, obs_req_after);
        end
    endtask

    task automatic test_load_ext();
        logic [3:0]  ops [3] = '{MEM_LB, MEM_LBU, MEM_LHU};
        logic [31:0] as  [3] = '{32'h1003, 32'h1003, 32'h1002};
        logic [31:0] ds  [3] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80010000};
        logic [31:0] ex  [3] = '{32'hFFFFFF80, 32'h00000080, 32'h00008001};
        for (int i = 0; i < 3; i++) begin
            run_txn(ops[i], as[i], 32'h0, ds[i], 1, 0);
            tests++;
            if (obs_rvalid !== 1'b1 || obs_rdata !== ex[i]) begin
                fails++; $display("FAIL load_ext[%0d]: rvalid=%b rdata=%h, required 1 %h", i, obs_rvalid, obs_rdata, ex[i]);
            end
        end
    endtask

    task automatic test_store();
        run_txn(MEM_SH, 32'h2002, 32'h1234ABCD, 32'h0, 2, 1);
        tests++;
        if (obs_we !== 1'b1 || obs_be !== 4'b1100 || obs_wdata !== 32'hABCDABCD || obs_addr !== 32'h2000) begin
            fails++; $display("FAIL sh_bus: we=%b be=%b wdata=%h addr=%h, required 1 1100 abcdabcd 00002000",
                              obs_we, obs_be, obs_wdata, obs_addr);
        end
        tests++;
        if (obs_rvalid !== 1'b0 || obs_rv_cnt != 0 || obs_stable_ok !== 1'b1) begin
            fails++; $display("FAIL sh_no_rvalid: rvalid=%b cnt=%0d stable=%b, required 0 0 1", obs_rvalid, obs_rv_cnt, obs_stable_ok);
        end
    endtask

    task automatic test_misalign();
        logic [3:0]  ops [2] = '{MEM_LW, MEM_SH};
        logic [31:0] as  [2] = '{32'h1001, 32'h2001};
        logic [4:0]  ex  [2] = '{5'd4, 5'd6};
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1; mem_oper = ops[i]; addr = as[i];
            #1;
            tests++;
            if (busy !== 1'b0) begin
                fails++; $display("FAIL misalign_busy[%0d]: busy=%b, required 0", i, busy);
            end
            tick();
            req_valid = 1'b0; mem_oper = MEM_NOP;
            tests++;
            if (misalign !== 1'b1 || exc_code !== ex[i] || bus_req !== 1'b0 || busy !== 1'b0) begin
                fails++; $display("FAIL misalign_exc[%0d]: misalign=%b code=%0d req=%b busy=%b, required 1 %0d 0 0",
                                  i, misalign, exc_code, bus_req, busy, ex[i]);
            end
            tick();
            tests++;
            if (misalign !== 1'b0 || bus_req !== 1'b0) begin
                fails++; $display("FAIL misalign_pulse[%0d]: misalign=%b req=%b, required 0 0", i, misalign, bus_req);
            end
        end
    endtask

    task automatic test_flush();
        // flush in IDLE blocks acceptance
        req_valid = 1'b1; mem_oper = MEM_LW; addr = 32'h3000; flush = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL flush_idle_busy: busy=%b, required 0", busy); end
        tick();
        req_valid = 1'b0; mem_oper = MEM_NOP; flush = 1'b0;
        tests++;
        if (bus_req !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL flush_idle_req: req=%b busy=%b, required 0 0", bus_req, busy);
        end
        // flush in REQ: grant withheld, flush on the 3rd request cycle
        req_valid = 1'b1; mem_oper = MEM_LW; addr = 32'h3004;
        tick();
        req_valid = 1'b0; mem_oper = MEM_NOP;
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests++;
        if (bus_req !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL flush_req: req=%b busy=%b, required 0 0", bus_req, busy);
        end
        // stray responses while IDLE are ignored
        bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h5555AAAA;
        tick();
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        tick();
        tests++;
        if (rvalid !== 1'b0 || bus_req !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL idle_stray: rvalid=%b req=%b busy=%b, required 0 0 0", rvalid, bus_req, busy);
        end
        // flush together with grant: response absorbed, result dropped
        req_valid = 1'b1; mem_oper = MEM_LW; addr = 32'h3008;
        tick();
        req_valid = 1'b0; mem_oper = MEM_NOP;
        flush = 1'b1; bus_gnt = 1'b1;
        tick();
        flush = 1'b0; bus_gnt = 1'b0;
        tests++;
        if (busy !== 1'b1 || bus_req !== 1'b0) begin
            fails++; $display("FAIL flush_gnt_wait: busy=%b req=%b, required 1 0", busy, bus_req);
        end
        bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
        tick();
        bus_rvalid = 1'b0;
        tests++;
        if (rvalid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL flush_gnt_drop: rvalid=%b busy=%b, required 0 0", rvalid, busy);
        end
        // flush in WAIT: busy held until rvalid, no result
        req_valid = 1'b1; mem_oper = MEM_LW; addr = 32'h300C;
        tick();
        req_valid = 1'b0; mem_oper = MEM_NOP; bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tests++;
        if (busy !== 1'b1 || rvalid !== 1'b0) begin
            fails++; $display("FAIL flush_wait_busy: busy=%b rvalid=%b, required 1 0", busy, rvalid);
        end
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
        tick();
        bus_rvalid = 1'b0;
        tests++;
        if (rvalid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL flush_wait_drop: rvalid=%b busy=%b, required 0 0", rvalid, busy);
        end
        // next load is delivered normally
        run_txn(MEM_LW, 32'h3010, 32'h0, 32'h0BADC0DE, 0, 2);
        tests++;
        if (obs_rvalid !== 1'b1 || obs_rdata !== 32'h0BADC0DE) begin
            fails++; $display("FAIL flush_recover: rvalid=%b rdata=%h, required 1 0badc0de", obs_rvalid, obs_rdata);
        end
    endtask

    task automatic test_reset_mid();
        // reset in REQ
        req_valid = 1'b1; mem_oper = MEM_LW; addr = 32'h4000;
        tick();
        req_valid = 1'b0; mem_oper = MEM_NOP;
        rst = 1'b1;
        #1;
        tests++;
        if (bus_req !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL rst_in_req: req=%b busy=%b, required 0 0", bus_req, busy);
        end
        tick();
        rst = 1'b0;
        // reset in WAIT
        req_valid = 1'b1; mem_oper = MEM_LW; addr = 32'h4004;
        tick();
        req_valid = 1'b0; mem_oper = MEM_NOP; bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        rst = 1'b1;
        #1;
        tests++;
        if (bus_req !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL rst_in_wait: req=%b busy=%b, required 0 0", bus_req, busy);
        end
        tick();
        rst = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hFEEDFACE;
        tick();
        bus_rvalid = 1'b0;
        tests++;
        if (rvalid !== 1'b0 || busy !== 1'b0 || bus_req !== 1'b0) begin
            fails++; $display("FAIL rst_stray: rvalid=%b busy=%b req=%b, required 0 0 0", rvalid, busy, bus_req);
        end
    endtask

    task automatic test_random();
        logic [3:0] ops [8] = '{MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW};
        logic [3:0]  op;
        logic [31:0] a, wd, rd;
        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(7)];
            a  = $urandom;
            if ($urandom_range(5) != 0) a = a - (a % m_bytes(op));
            wd = $urandom;
            rd = $urandom;
            if (m_misaligned(op, a)) begin
                req_valid = 1'b1; mem_oper = op; addr = a;
                #1;
                tests++;
                if (busy !== 1'b0) begin fails++; $display("FAIL rnd_mis_busy[%0d]: busy=%b, required 0", n, busy); end
                tick();
                req_valid = 1'b0; mem_oper = MEM_NOP;
                tests++;
                if (misalign !== 1'b1 || exc_code !== (m_store(op) ? 5'd6 : 5'd4) || bus_req !== 1'b0) begin
                    fails++; $display("FAIL rnd_mis[%0d]: op=%0d misalign=%b code=%0d req=%b, required 1 %0d 0",
                                      n, op, misalign, exc_code, bus_req, m_store(op) ? 6 : 4);
                end
                tick();
            end else begin
                run_txn(op, a, wd, rd, $urandom_range(3), $urandom_range(3));
                tests++;
                if (obs_we !== m_store(op) || obs_be !== m_be(op, a) || obs_addr !== (a & 32'hFFFF_FFFC) ||
                    (m_store(op) && obs_wdata !== m_wdata(op, wd)) || obs_stable_ok !== 1'b1 || obs_req_ok !== 1'b1) begin
                    fails++; $display("FAIL rnd_bus[%0d]: op=%0d we=%b be=%b addr=%h wdata=%h stable=%b req=%b, required %b %b %h %h 1 1",
                                      n, op, obs_we, obs_be, obs_addr, obs_wdata, obs_stable_ok, obs_req_ok,
                                      m_store(op), m_be(op, a), a & 32'hFFFF_FFFC, m_wdata(op, wd));
                end
                tests++;
                if (obs_rvalid !== !m_store(op) || (!m_store(op) && obs_rdata !== m_load(op, a, rd)) ||
                    obs_rv_cnt != 0 || obs_busy0 !== 1'b1 || obs_busy_ok !== 1'b1 || obs_busy_end !== 1'b0) begin
                    fails++; $display("FAIL rnd_rsp[%0d]: op=%0d rvalid=%b rdata=%h extra=%0d busy=%b%b%b, required %b %h 0 110",
                                      n, op, obs_rvalid, obs_rdata, obs_rv_cnt, obs_busy0, obs_busy_ok, obs_busy_end,
                                      !m_store(op), m_load(op, a, rd));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw_basic();
        test_load_ext();
        test_store();
        test_misalign();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
